// File: rtl/modulo_contador_garrafas_bcd.sv
// Bottle counter: synchronised, debounced sensor feeding a BCD batch counter
// with a batch-full flag held until the box-release acknowledge.
module modulo_contador_garrafas_bcd #(
    parameter int MAX_DEZ    = 1,
    parameter int MAX_UNI    = 2,
    parameter int DEB_CICLOS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    input  logic       habilita,
    input  logic       limpa,
    input  logic       ack,
    output logic [3:0] unidade,
    output logic [3:0] dezena,
    output logic       cheio,
    output logic       pulso_lote,
    output logic [1:0] estado
);

    localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam logic [CW-1:0] DEB_FIM = CW'(DEB_CICLOS - 1);
    localparam logic [3:0] LIM_D = 4'(MAX_DEZ);
    localparam logic [3:0] LIM_U = 4'(MAX_UNI);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        CHEIO    = 2'b10
    } estado_t;

    estado_t st, st_n;

    logic          s1, s2, f;
    logic [CW-1:0] run;
    logic          sobe;
    logic          evento;

    logic [3:0] uni_r, dez_r;
    logic [3:0] uni_n, dez_n;
    logic [3:0] uni_inc, dez_inc;
    logic       cheio_r, cheio_n;
    logic       pulso_r, pulso_n;

    // f rises on the same edge that completes the run of high samples
    assign sobe   = s2 && !f && (run == DEB_FIM);
    assign evento = sobe && (st == CONTANDO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            f   <= 1'b0;
            run <= '0;
        end else begin
            s1 <= sensor;
            s2 <= s1;
            if (s2 == f) begin
                run <= '0;
            end else if (run == DEB_FIM) begin
                f   <= s2;
                run <= '0;
            end else begin
                run <= run + CW'(1);
            end
        end
    end

    always_comb begin
        uni_inc = uni_r + 4'd1;
        dez_inc = dez_r;
        if (uni_r >= 4'd9) begin
            uni_inc = 4'd0;
            dez_inc = (dez_r >= 4'd9) ? 4'd0 : dez_r + 4'd1;
        end
    end

    always_comb begin
        st_n    = st;
        uni_n   = uni_r;
        dez_n   = dez_r;
        cheio_n = cheio_r;
        pulso_n = 1'b0;
        if (limpa) begin
            uni_n   = 4'd0;
            dez_n   = 4'd0;
            cheio_n = 1'b0;
            st_n    = habilita ? CONTANDO : PARADO;
        end else begin
            case (st)
                PARADO: begin
                    if (habilita) st_n = CONTANDO;
                end
                CONTANDO: begin
                    if (evento) begin
                        uni_n = uni_inc;
                        dez_n = dez_inc;
                    end
                    if (evento && {dez_inc, uni_inc} == {LIM_D, LIM_U}) begin
                        st_n    = CHEIO;
                        cheio_n = 1'b1;
                        pulso_n = 1'b1;
                    end else if (!habilita) begin
                        st_n = PARADO;
                    end
                end
                CHEIO: begin
                    if (ack) begin
                        uni_n   = 4'd0;
                        dez_n   = 4'd0;
                        cheio_n = 1'b0;
                        st_n    = habilita ? CONTANDO : PARADO;
                    end
                end
                default: st_n = PARADO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= PARADO;
            uni_r   <= 4'd0;
            dez_r   <= 4'd0;
            cheio_r <= 1'b0;
            pulso_r <= 1'b0;
        end else begin
            st      <= st_n;
            uni_r   <= uni_n;
            dez_r   <= dez_n;
            cheio_r <= cheio_n;
            pulso_r <= pulso_n;
        end
    end

    assign unidade    = uni_r;
    assign dezena     = dez_r;
    assign cheio      = cheio_r;
    assign pulso_lote = pulso_r;
    assign estado     = st;

endmodule

// File: tb/tb_modulo_contador_garrafas_bcd.sv
// Scoreboard bench: stimulus queues every expected output change, a negedge
// monitor pops and compares each change the counter presents.
module tb_modulo_contador_garrafas_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor;
    logic       habilita;
    logic       limpa;
    logic       ack;
    logic [3:0] unidade;
    logic [3:0] dezena;
    logic       cheio;
    logic       pulso_lote;
    logic [1:0] estado;

    modulo_contador_garrafas_bcd #(
        .MAX_DEZ(1),
        .MAX_UNI(2),
        .DEB_CICLOS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sensor(sensor),
        .habilita(habilita),
        .limpa(limpa),
        .ack(ack),
        .unidade(unidade),
        .dezena(dezena),
        .cheio(cheio),
        .pulso_lote(pulso_lote),
        .estado(estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] cur;
    logic [11:0] last = 12'hfff;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mk(input int d, input int u,
                                       input bit ch, input bit pu,
                                       input int st);
        logic [3:0] d4, u4;
        logic [1:0] s2b;
        d4  = 4'(d);
        u4  = 4'(u);
        s2b = 2'(st);
        return {d4, u4, ch, pu, s2b};
    endfunction

    task automatic push(input logic [11:0] v, input int c);
        exp_t x;
        x.v = v;
        x.c = c;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // counted bottle: change expected on edge 6 after the rise
    task automatic bottle(input bit cnt, input logic [11:0] v);
        int k;
        tick();
        sensor = 1'b1;
        k = cyc;
        if (cnt) begin
            push(v, k + 6);
            if (v[2]) push(v & 12'hffb, k + 7);
        end
        repeat (10) tick();
        sensor = 1'b0;
        repeat (10) tick();
    endtask

    task automatic glitch(input int w);
        tick();
        sensor = 1'b1;
        repeat (w) tick();
        sensor = 1'b0;
        repeat (8) tick();
    endtask

    always @(negedge clk) begin
        cur = {dezena, unidade, cheio, pulso_lote, estado};
        if (cur !== last) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h at cycle %0d, required no change from %h",
                         cur, cyc, last);
            end else begin
                e = sb.pop_front();
                if (cur !== e.v || (e.c >= 0 && e.c != cyc)) begin
                    errors++;
                    $display("FAIL out_vec: got %h at cycle %0d, required %h at cycle %0d",
                             cur, cyc, e.v, e.c);
                end
            end
            last = cur;
        end
    end

    initial begin
        rst      = 1'b1;
        sensor   = 1'b0;
        habilita = 1'b0;
        limpa    = 1'b0;
        ack      = 1'b0;
        push(mk(0, 0, 0, 0, 0), -1);
        repeat (3) tick();
        rst      = 1'b0;
        habilita = 1'b1;
        push(mk(0, 0, 0, 0, 1), cyc + 1);
        repeat (2) tick();

        // short glitches never count
        for (int r = 0; r < 2; r++)
            for (int w = 1; w <= 3; w++) glitch(w);

        bottle(1'b1, mk(0, 1, 0, 0, 1));

        // bounce around one valid pulse
        push(mk(0, 2, 0, 0, 1), -1);
        tick(); sensor = 1'b1;
        tick(); sensor = 1'b0;
        tick(); sensor = 1'b1;
        repeat (2) tick(); sensor = 1'b0;
        tick(); sensor = 1'b1;
        repeat (10) tick(); sensor = 1'b0;
        tick(); sensor = 1'b1;
        tick(); sensor = 1'b0;
        repeat (10) tick();

        for (int n = 3; n <= 11; n++) bottle(1'b1, mk(n / 10, n % 10, 0, 0, 1));
        bottle(1'b1, mk(1, 2, 1, 1, 2));
        bottle(1'b0, '0);

        // habilita has no effect while full
        tick(); habilita = 1'b0;
        repeat (3) tick(); habilita = 1'b1;
        repeat (2) tick();

        tick(); ack = 1'b1;
        push(mk(0, 0, 0, 0, 1), cyc + 1);
        tick(); ack = 1'b0;
        bottle(1'b1, mk(0, 1, 0, 0, 1));

        // ack outside full is ignored
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        repeat (2) tick();

        for (int n = 2; n <= 5; n++) bottle(1'b1, mk(0, n, 0, 0, 1));

        tick(); habilita = 1'b0;
        push(mk(0, 5, 0, 0, 0), cyc + 1);
        repeat (3) bottle(1'b0, '0);
        tick(); habilita = 1'b1;
        push(mk(0, 5, 0, 0, 1), cyc + 1);
        bottle(1'b1, mk(0, 6, 0, 0, 1));
        bottle(1'b1, mk(0, 7, 0, 0, 1));

        // limpa on the same edge as a count event at 7
        begin
            int k;
            tick();
            sensor = 1'b1;
            k = cyc;
            push(mk(0, 0, 0, 0, 1), k + 6);
            repeat (5) tick();
            limpa = 1'b1;
            tick();
            limpa = 1'b0;
            repeat (4) tick();
            sensor = 1'b0;
            repeat (10) tick();
        end

        for (int n = 1; n <= 11; n++) bottle(1'b1, mk(n / 10, n % 10, 0, 0, 1));

        // async reset takes effect before the next edge
        tick();
        push(mk(0, 0, 0, 0, 0), cyc);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        push(mk(0, 0, 0, 0, 1), cyc + 1);
        repeat (2) tick();
        bottle(1'b1, mk(0, 1, 0, 0, 1));

        repeat (20) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending changes, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulo_contador_garrafas_bcd.md
Name: modulo_contador_garrafas_bcd

Overview:
Bottle counter that produces the 4-bit BCD units digit consumed by the units-digit display encoder. It also produces the tens digit for the tens-digit encoder. It synchronises and debounces the conveyor bottle sensor, counts bottles in BCD up to a batch capacity, and raises a batch-full flag. The flag is held until the box-release logic acknowledges it, and the acknowledge clears the count.

Parameters:
MAX_DEZ, 1, tens digit of batch capacity (BCD, 0-9)
MAX_UNI, 2, units digit of batch capacity (BCD, 0-9); capacity = 10*MAX_DEZ+MAX_UNI, must be >= 1
DEB_CICLOS, 4, consecutive synchronised samples required to change the filtered sensor level (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
sensor  input  1  raw bottle sensor, asynchronous level, 1 = bottle present
habilita  input  1  conveyor running; counting only when 1
limpa  input  1  synchronous clear of count and flag
ack  input  1  box released; clears a full batch
unidade  output  4  BCD units digit; feeds the units encoder input
dezena  output  4  BCD tens digit
cheio  output  1  batch full, level
pulso_lote  output  1  one-cycle pulse when the batch becomes full
estado  output  2  FSM state: 00 PARADO, 01 CONTANDO, 10 CHEIO

Behaviour:
- Reset (async, rst=1): unidade=0, dezena=0, cheio=0, pulso_lote=0, estado=PARADO. Synchronisers, debounce counter and filtered level are all 0.
- Sensor path: 2-flop synchroniser (s1, s2).
- Debounce:
  - Filtered level f changes only after s2 has differed from f for DEB_CICLOS consecutive clocks.
  - The run counter restarts whenever s2 equals f.
- Count event: a rising edge of f while estado=CONTANDO.
- Count latency: with sensor rising before clock edge 1 and held steady, f and the count update on edge 2+DEB_CICLOS. For DEB_CICLOS=4 this is edge 6.
- Sensor glitches shorter than DEB_CICLOS synchronised cycles produce no count.
- BCD arithmetic:
  - unidade increments 0..9.
  - At 9, unidade wraps to 0 and dezena increments.
  - dezena never exceeds 9. Values above 9 never appear on either output.
- FSM:
  - PARADO: no counting; the count is held. Goes to CONTANDO when habilita=1.
  - CONTANDO: counts events. Goes to PARADO when habilita=0; the count is held.
  - CONTANDO to CHEIO: when the count event makes {dezena,unidade} equal {MAX_DEZ,MAX_UNI}. cheio=1 and pulso_lote=1 are registered on that same edge. pulso_lote lasts exactly one cycle.
  - CHEIO: further sensor edges are ignored (not counted, not queued). habilita has no effect.
  - CHEIO on ack=1: next edge sets count=0, cheio=0, and estado=CONTANDO if habilita=1, otherwise PARADO.
- limpa=1, any state: next edge sets count=0, cheio=0, pulso_lote=0, and estado=CONTANDO if habilita=1, otherwise PARADO. limpa has priority over ack and over a coincident count event; that event is discarded.
- ack outside CHEIO: ignored.
- Count event and habilita falling on the same edge: the event is counted, then the FSM enters PARADO.
- A rising edge of f that occurs while not in CONTANDO is lost. It is not counted later.
- rst asserted mid-count or in CHEIO: immediate return to reset values. The debounce state is lost.
- Outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset, habilita=1, DEB_CICLOS=4, one clean sensor pulse 10 cycles wide -> unidade 0->1 after edge 6 from the sensor rise; dezena=0; cheio=0.
- Sensor glitches 1-3 cycles wide, repeated -> unidade stays 0. Sensor bounce around a valid pulse -> exactly one count.
- 12 clean pulses with defaults -> count 0..9, then 10 (unidade=0, dezena=1), 11, 12. At 12: cheio=1, pulso_lote=1 for one cycle, estado=10. A 13th pulse -> still 12.
- In CHEIO, ack=1 for one cycle -> next edge: unidade=0, dezena=0, cheio=0, estado=01. Next pulse -> unidade=1.
- habilita=0 at count 5, then 3 pulses -> count stays 5, estado=00. habilita=1 and 1 pulse -> 6.
- limpa asserted on the same edge as a count event at count 7 -> count=0 with the event discarded. rst pulse at count 11 -> all outputs 0 immediately, before the next clock edge.
